cpu_step_ctrl: RTL and testbench

//   Clock-enable generator feeding the single-cycle MIPS datapath (PC, register file, data memory).

---
 rtl/cpu_step_ctrl_pkg.sv | 18 +
 rtl/cpu_step_ctrl_debounce.sv | 41 ++++
 rtl/cpu_step_ctrl.sv | 128 ++++++++++++
 tb/tb_cpu_step_ctrl.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/cpu_step_ctrl_pkg.sv
// Shared mode encodings for the CPU step/run clock-enable controller.
package cpu_ctrl_pkg;

  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] ST_STEP = 2'd0;
  localparam logic [MODE_W-1:0] ST_RUN  = 2'd1;
  localparam logic [MODE_W-1:0] ST_HALT = 2'd2;

  // Encoding 2'd3 is kept as a named member so the FSM can recover from it.
  typedef enum logic [MODE_W-1:0] {
    MODE_STEP = ST_STEP,
    MODE_RUN  = ST_RUN,
    MODE_HALT = ST_HALT,
    MODE_RSVD = 2'd3
  } mode_e;

endpackage

// File: rtl/cpu_step_ctrl_debounce.sv
// Two-flop synchronizer followed by a stability counter; dout flips only after
// the synchronized input has differed from it for DEBOUNCE_CYCLES clocks.
module debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]    sync_r;
  logic          stable_r;
  logic [CW-1:0] cnt_r;

  // Synchronize the raw input and qualify level changes by a run of stable samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r   <= 2'b00;
      stable_r <= 1'b0;
      cnt_r    <= '0;
    end else begin
      sync_r <= {sync_r[0], din};
      if (sync_r[1] == stable_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_LAST) begin
        stable_r <= ~stable_r;
        cnt_r    <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  assign dout = stable_r;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Clock-enable generator for the single-cycle CPU: single-step on a debounced
// button press, free-run from a divider, or halt on request; counts issued enables.
module cpu_step_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RUN_DIV         = 25000000,
  parameter int CNT_W           = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_step,
  input  logic              sw_run,
  input  logic              halt_in,
  output logic              cpu_en,
  output logic [MODE_W-1:0] mode,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam int DIV_W = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             btn_db_s;
  logic             run_db_s;
  logic             btn_prev_r;
  logic             btn_rise_s;
  mode_e            state_r;
  mode_e            state_s;
  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] div_s;
  logic             en_s;
  logic             en_safe_s;
  logic             cpu_en_r;
  logic [CNT_W-1:0] count_r;

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_btn (
    .clk  (clk),
    .rst  (rst),
    .din  (btn_step),
    .dout (btn_db_s)
  );

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .clk  (clk),
    .rst  (rst),
    .din  (sw_run),
    .dout (run_db_s)
  );

  assign btn_rise_s = btn_db_s & ~btn_prev_r;

  // Next-state, divider and enable decode; halt and mode changes pre-empt any pulse.
  always_comb begin
    state_s = state_r;
    div_s   = div_r;
    en_s    = 1'b0;
    case (state_r)
      MODE_STEP: begin
        if (halt_in) begin
          state_s = MODE_HALT;
        end else if (run_db_s) begin
          state_s = MODE_RUN;
          div_s   = '0;
        end else if (btn_rise_s) begin
          en_s = 1'b1;
        end else begin
          en_s = 1'b0;
        end
      end
      MODE_RUN: begin
        if (halt_in) begin
          state_s = MODE_HALT;
        end else if (!run_db_s) begin
          state_s = MODE_STEP;
          div_s   = '0;
        end else if (div_r == DIV_LAST) begin
          en_s  = 1'b1;
          div_s = '0;
        end else begin
          div_s = div_r + DIV_ONE;
        end
      end
      MODE_HALT: begin
        div_s = '0;
        if (!run_db_s && !halt_in) begin
          state_s = MODE_STEP;
        end else begin
          state_s = MODE_HALT;
        end
      end
      default: begin
        state_s = MODE_STEP;
        div_s   = '0;
      end
    endcase
  end

  // Back-to-back enables cannot arise from the decode; the mask keeps that true regardless.
  assign en_safe_s = en_s & ~cpu_en_r;

  // State, divider, edge history, registered enable and cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= MODE_STEP;
      div_r      <= '0;
      btn_prev_r <= 1'b0;
      cpu_en_r   <= 1'b0;
      count_r    <= '0;
    end else begin
      state_r    <= state_s;
      div_r      <= div_s;
      btn_prev_r <= btn_db_s;
      cpu_en_r   <= en_safe_s;
      if (en_safe_s) begin
        count_r <= count_r + CNT_ONE;
      end else begin
        count_r <= count_r;
      end
    end
  end

  assign cpu_en      = cpu_en_r;
  assign mode        = state_r;
  assign cycle_count = count_r;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed self-checking bench for cpu_step_ctrl with short debounce/divider settings.
module tb_cpu_step_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_step;
  logic       sw_run;
  logic       halt_in;
  logic       cpu_en;
  logic [1:0] mode;
  logic [3:0] cycle_count;

  int   errors    = 0;
  int   checks    = 0;
  int   pulse_cnt = 0;
  int   adj_cnt   = 0;
  logic prev_en   = 1'b0;
  int   p0;

  always #5 clk = ~clk;

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .RUN_DIV         (5),
    .CNT_W           (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_step    (btn_step),
    .sw_run      (sw_run),
    .halt_in     (halt_in),
    .cpu_en      (cpu_en),
    .mode        (mode),
    .cycle_count (cycle_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: advance past a posedge, sample on the following negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (cpu_en === 1'b1) begin
      pulse_cnt++;
      if (prev_en) adj_cnt++;
    end
    prev_en = cpu_en;
  endtask

  task automatic press();
    btn_step = 1'b1;
    repeat (6) tick();
    btn_step = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    rst = 1'b1; btn_step = 1'b0; sw_run = 1'b0; halt_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_en", 32'(cpu_en), 0);
    check("rst_mode", 32'(mode), 0);
    check("rst_cnt", 32'(cycle_count), 0);
    rst = 1'b0;
    tick();

    // Step: one pulse on the 7th posedge of a long hold
    btn_step = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check("step_en", 32'(cpu_en), (i == 7) ? 1 : 0);
    end
    check("step_cnt", 32'(cycle_count), 1);
    p0 = pulse_cnt;
    btn_step = 1'b0;
    repeat (8) tick();
    check("release_nopulse", pulse_cnt, p0);
    btn_step = 1'b1;
    repeat (3) tick();
    btn_step = 1'b0;
    repeat (10) tick();
    check("glitch_nopulse", pulse_cnt, p0);
    check("glitch_cnt", 32'(cycle_count), 1);

    // Run, ignored button, halt on terminal count, halt hold and exit
    sw_run = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      check("run_en", 32'(cpu_en), (i == 12 || i == 17 || i == 22 || i == 27) ? 1 : 0);
      check("run_mode", 32'(mode), (i < 7) ? 0 : (i < 32) ? 1 : (i < 47) ? 2 : 0);
      if (i == 8)  btn_step = 1'b1;
      if (i == 20) btn_step = 1'b0;
      if (i == 31) halt_in  = 1'b1;
      if (i == 33) btn_step = 1'b1;
      if (i == 36) halt_in  = 1'b0;
      if (i == 38) btn_step = 1'b0;
      if (i == 40) sw_run   = 1'b0;
    end
    check("run_cnt", 32'(cycle_count), 5);

    // RUN->STEP with divider at 3, then fresh RUN entry waits a full period
    sw_run = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      tick();
      check("flip_en", 32'(cpu_en), (j == 12 || j == 17 || j == 37) ? 1 : 0);
      check("flip_mode", 32'(mode), (j < 7) ? 0 : (j < 21) ? 1 : (j < 32) ? 0 : 1);
      if (j == 14) sw_run = 1'b0;
      if (j == 25) sw_run = 1'b1;
    end
    check("flip_cnt", 32'(cycle_count), 8);

    // Asynchronous reset mid-RUN (divider at 3)
    rst = 1'b1;
    sw_run = 1'b0;
    #1;
    check("arst_en", 32'(cpu_en), 0);
    check("arst_mode", 32'(mode), 0);
    check("arst_cnt", 32'(cycle_count), 0);
    repeat (2) @(negedge clk);
    check("arst_hold_mode", 32'(mode), 0);
    check("arst_hold_cnt", 32'(cycle_count), 0);
    rst = 1'b0;
    prev_en = 1'b0;
    tick();

    // Wrap: 16 back-to-back presses return the 4-bit count to 0
    p0 = pulse_cnt;
    for (int k = 1; k <= 16; k++) begin
      press();
      if (k == 15) check("wrap_cnt15", 32'(cycle_count), 15);
    end
    check("wrap_cnt0", 32'(cycle_count), 0);
    check("wrap_pulses", pulse_cnt - p0, 16);
    check("wrap_mode", 32'(mode), 0);
    check("no_adjacent_en", adj_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
